// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset, load div/mul, wait for lock with timeout/retry,
// settle, then hand the SoC clock to the PLL; falls back to xo_clk on loss or error.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int MAX_RETRIES   = 3
) (
    input  logic        i_clk_ahb,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic        i_clear_err,
    input  logic        i_bypass,
    input  logic [7:0]  i_cfg_div,
    input  logic [7:0]  i_cfg_mul,
    input  logic [31:0] i_lock_timeout,
    input  logic        pll_locked,
    input  logic        pll_error,
    output logic        pll_reset,
    output logic        pll_enable,
    output logic        pll_bypass,
    output logic [7:0]  pll_div,
    output logic [7:0]  pll_mul,
    output logic        soc_clk_select,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout_err,
    output logic        o_lock_lost,
    output logic [1:0]  o_retry_cnt,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET_PLL = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_RUN       = 3'd4,
        S_BYPASS    = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    state_t            state, state_nxt;
    logic [RW-1:0]     rst_cnt, rst_cnt_nxt;
    logic [SW-1:0]     settle_cnt, settle_cnt_nxt;
    logic [31:0]       wait_cnt, wait_cnt_nxt, wait_inc;
    logic [1:0]        retry_nxt;
    logic              timeout_err_nxt, lock_lost_nxt, fail, timed_out;
    logic [7:0]        div_nxt, mul_nxt;
    logic [SYNC_STAGES-1:0] lock_sync, err_sync;
    logic              lock_s, err_s;

    always_ff @(posedge i_clk_ahb or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync <= '0;
            err_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
            err_sync  <= {err_sync[SYNC_STAGES-2:0], pll_error};
        end
    end

    assign lock_s    = lock_sync[SYNC_STAGES-1];
    assign err_s     = err_sync[SYNC_STAGES-1];
    assign wait_inc  = wait_cnt + 32'd1;
    assign timed_out = (i_lock_timeout != 32'd0) && (wait_inc == i_lock_timeout);

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_nxt       = state;
        rst_cnt_nxt     = '0;
        settle_cnt_nxt  = '0;
        wait_cnt_nxt    = wait_cnt;
        retry_nxt       = o_retry_cnt;
        timeout_err_nxt = o_timeout_err;
        lock_lost_nxt   = o_lock_lost;
        div_nxt         = pll_div;
        mul_nxt         = pll_mul;
        fail            = 1'b0;

        case (state)
            S_RESET_PLL: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt    = S_WAIT_LOCK;
                    wait_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                wait_cnt_nxt = wait_inc;
                if (err_s) begin
                    fail = 1'b1;
                end else if (lock_s) begin
                    // The lock-detect cycle counts as the first settle cycle.
                    if (SETTLE_CYCLES <= 1) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt      = S_SETTLE;
                        settle_cnt_nxt = SW'(1);
                    end
                end else if (timed_out) begin
                    fail = 1'b1;
                end
            end
            S_SETTLE: begin
                if (err_s) begin
                    fail = 1'b1;
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_RUN;
                end else begin
                    settle_cnt_nxt = settle_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s || err_s) begin
                    lock_lost_nxt = 1'b1;
                    retry_nxt     = '0;
                    state_nxt     = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (i_clear_err) begin
                    state_nxt       = S_IDLE;
                    timeout_err_nxt = 1'b0;
                end
            end
            default: ;
        endcase

        if (fail) begin
            if (o_retry_cnt < RETRY_MAX) begin
                retry_nxt = o_retry_cnt + 2'd1;
                state_nxt = S_RESET_PLL;
            end else begin
                timeout_err_nxt = 1'b1;
                state_nxt       = S_FAIL;
            end
        end

        // A start request overrides every other event in the same cycle.
        if (i_start) begin
            div_nxt       = (i_cfg_div == 8'd0) ? 8'd1 : i_cfg_div;
            mul_nxt       = (i_cfg_mul == 8'd0) ? 8'd1 : i_cfg_mul;
            retry_nxt     = '0;
            lock_lost_nxt = 1'b0;
            rst_cnt_nxt   = '0;
            state_nxt     = i_bypass ? S_BYPASS : S_RESET_PLL;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as it.
    always_ff @(posedge i_clk_ahb or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            settle_cnt     <= '0;
            wait_cnt       <= '0;
            o_retry_cnt    <= '0;
            o_timeout_err  <= 1'b0;
            o_lock_lost    <= 1'b0;
            pll_div        <= 8'd1;
            pll_mul        <= 8'd1;
            pll_reset      <= 1'b1;
            pll_enable     <= 1'b0;
            pll_bypass     <= 1'b0;
            soc_clk_select <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_nxt;
            rst_cnt        <= rst_cnt_nxt;
            settle_cnt     <= settle_cnt_nxt;
            wait_cnt       <= wait_cnt_nxt;
            o_retry_cnt    <= retry_nxt;
            o_timeout_err  <= timeout_err_nxt;
            o_lock_lost    <= lock_lost_nxt;
            pll_div        <= div_nxt;
            pll_mul        <= mul_nxt;
            pll_enable     <= state_nxt inside {S_WAIT_LOCK, S_SETTLE, S_RUN};
            pll_reset      <= !(state_nxt inside {S_WAIT_LOCK, S_SETTLE, S_RUN});
            pll_bypass     <= (state_nxt == S_BYPASS);
            soc_clk_select <= (state_nxt == S_RUN);
            o_busy         <= state_nxt inside {S_RESET_PLL, S_WAIT_LOCK, S_SETTLE};
            o_done         <= (state_nxt == S_RUN) && (state != S_RUN);
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: bring-up, timeout/retry, settle glitch,
// lock loss in RUN, bypass and config saturation.
module tb_pll_lock_sequencer;

    logic        i_clk_ahb = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_clear_err = 1'b0;
    logic        i_bypass = 1'b0;
    logic [7:0]  i_cfg_div = 8'd0;
    logic [7:0]  i_cfg_mul = 8'd0;
    logic [31:0] i_lock_timeout = 32'd0;
    logic        pll_locked = 1'b0;
    logic        pll_error = 1'b0;
    logic        pll_reset, pll_enable, pll_bypass, soc_clk_select;
    logic [7:0]  pll_div, pll_mul;
    logic        o_busy, o_done, o_timeout_err, o_lock_lost;
    logic [1:0]  o_retry_cnt;
    logic [2:0]  o_state;

    int errors = 0;
    int checks = 0;

    pll_lock_sequencer dut (
        .i_clk_ahb(i_clk_ahb), .reset_n(reset_n), .i_start(i_start),
        .i_clear_err(i_clear_err), .i_bypass(i_bypass), .i_cfg_div(i_cfg_div),
        .i_cfg_mul(i_cfg_mul), .i_lock_timeout(i_lock_timeout),
        .pll_locked(pll_locked), .pll_error(pll_error), .pll_reset(pll_reset),
        .pll_enable(pll_enable), .pll_bypass(pll_bypass), .pll_div(pll_div),
        .pll_mul(pll_mul), .soc_clk_select(soc_clk_select), .o_busy(o_busy),
        .o_done(o_done), .o_timeout_err(o_timeout_err), .o_lock_lost(o_lock_lost),
        .o_retry_cnt(o_retry_cnt), .o_state(o_state)
    );

    always #5 i_clk_ahb = ~i_clk_ahb;

    // {state, reset, enable, bypass, soc_sel, busy, done, timeout_err, lock_lost, retry}
    wire [12:0] status = {o_state, pll_reset, pll_enable, pll_bypass, soc_clk_select,
                          o_busy, o_done, o_timeout_err, o_lock_lost, o_retry_cnt};
    localparam logic [12:0] RESET_STATUS = {3'd0, 1'b1, 7'b0000000, 2'd0};

    task automatic step();
        @(posedge i_clk_ahb);
        #1;
    endtask

    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while (o_state === s && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
        int n = 0;
        while (o_state !== s && n < limit) begin
            step();
            n++;
        end
        ok = (o_state === s);
    endtask

    task automatic pulse_start(input logic [7:0] div, input logic [7:0] mul,
                               input logic byp, input logic [31:0] to);
        i_cfg_div = div;
        i_cfg_mul = mul;
        i_bypass = byp;
        i_lock_timeout = to;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        checks++; if (status !== RESET_STATUS) begin errors++;
            $display("FAIL reset_status got=%b want=%b", status, RESET_STATUS); end
        checks++; if ({pll_div, pll_mul} !== 16'h0101) begin errors++;
            $display("FAIL reset_divmul got=%h want=0101", {pll_div, pll_mul}); end
        pulse_start(8'd7, 8'd9, 1'b0, 32'd0);
        wait_state(3'd2, 40, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL reset_reach_wait got=%0d want=2", o_state); end
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        checks++; if (status !== RESET_STATUS) begin errors++;
            $display("FAIL midseq_reset_status got=%b want=%b", status, RESET_STATUS); end
        checks++; if ({pll_div, pll_mul} !== 16'h0101) begin errors++;
            $display("FAIL midseq_reset_divmul got=%h want=0101", {pll_div, pll_mul}); end
        step();
        reset_n = 1'b1;
        step();
        checks++; if (status !== RESET_STATUS) begin errors++;
            $display("FAIL post_release_status got=%b want=%b", status, RESET_STATUS); end
    endtask

    task automatic test_bringup();
        int n;
        pulse_start(8'd4, 8'd20, 1'b0, 32'd1000);
        checks++; if ({pll_div, pll_mul} !== {8'd4, 8'd20}) begin errors++;
            $display("FAIL bringup_divmul got=%h want=0414", {pll_div, pll_mul}); end
        count_state(3'd1, n);
        checks++; if (n !== 16) begin errors++;
            $display("FAIL bringup_reset_len got=%0d want=16", n); end
        checks++; if ({pll_reset, pll_enable, o_busy, o_state} !== {3'b011, 3'd2}) begin errors++;
            $display("FAIL bringup_wait_outputs got=%b want=011010",
                     {pll_reset, pll_enable, o_busy, o_state}); end
        repeat (10) step();
        pll_locked = 1'b1;
        n = 0;
        while (soc_clk_select !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n !== 10) begin errors++;
            $display("FAIL bringup_lock_to_run got=%0d want=10", n); end
        checks++; if ({o_done, o_state, o_retry_cnt} !== {1'b1, 3'd4, 2'd0}) begin errors++;
            $display("FAIL bringup_run got=%b want=1100 00", {o_done, o_state, o_retry_cnt}); end
        step();
        checks++; if ({o_done, soc_clk_select} !== 2'b01) begin errors++;
            $display("FAIL bringup_done_pulse got=%b want=01", {o_done, soc_clk_select}); end
    endtask

    task automatic test_timeout();
        int n1, n2;
        pll_locked = 1'b0;
        pulse_start(8'd2, 8'd3, 1'b0, 32'd50);
        for (int a = 0; a < 4; a++) begin
            checks++; if (o_retry_cnt !== 2'(a)) begin errors++;
                $display("FAIL timeout_retry_%0d got=%0d want=%0d", a, o_retry_cnt, a); end
            count_state(3'd1, n1);
            count_state(3'd2, n2);
            checks++; if (n1 !== 16 || n2 !== 50) begin errors++;
                $display("FAIL timeout_attempt_%0d got=%0d/%0d want=16/50", a, n1, n2); end
        end
        checks++; if (status !== {3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3}) begin
            errors++; $display("FAIL timeout_fail_status got=%b", status); end
        i_clear_err = 1'b1;
        step();
        i_clear_err = 1'b0;
        checks++; if ({o_state, o_timeout_err} !== {3'd0, 1'b0}) begin errors++;
            $display("FAIL clear_err got=%b want=0000", {o_state, o_timeout_err}); end
    endtask

    task automatic test_settle_glitch();
        int n;
        bit ok, saw_done;
        pulse_start(8'd4, 8'd20, 1'b0, 32'd1000);
        count_state(3'd1, n);
        pll_locked = 1'b1;
        wait_state(3'd3, 10, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL glitch_reach_settle got=%0d want=3", o_state); end
        repeat (4) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        n = 0;
        saw_done = 1'b0;
        while (o_state !== 3'd2 && n < 10) begin
            if (o_done) saw_done = 1'b1;
            step();
            n++;
        end
        checks++; if (o_state !== 3'd2 || saw_done) begin errors++;
            $display("FAIL glitch_back_to_wait got=%0d done=%0d want=2 done=0", o_state, saw_done); end
        n = 0;
        while (o_state !== 3'd4 && n < 40) begin
            step();
            n++;
        end
        checks++; if (n !== 8 || o_done !== 1'b1) begin errors++;
            $display("FAIL glitch_relock got=%0d done=%0d want=8 done=1", n, o_done); end
    endtask

    task automatic test_lock_loss();
        int n;
        bit ok;
        pll_error = 1'b1;
        step();
        pll_error = 1'b0;
        n = 1;
        while (soc_clk_select === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 3) begin errors++;
            $display("FAIL loss_latency got=%0d want=3", n); end
        checks++; if ({o_lock_lost, o_state, o_retry_cnt} !== {1'b1, 3'd1, 2'd0}) begin errors++;
            $display("FAIL loss_flags got=%b want=100100", {o_lock_lost, o_state, o_retry_cnt}); end
        count_state(3'd1, n);
        checks++; if (n !== 16) begin errors++;
            $display("FAIL loss_reset_len got=%0d want=16", n); end
        wait_state(3'd4, 40, ok);
        checks++; if (!ok || o_lock_lost !== 1'b1) begin errors++;
            $display("FAIL loss_relock got=%0d lost=%0d want=4 lost=1", o_state, o_lock_lost); end
        pulse_start(8'd4, 8'd20, 1'b0, 32'd1000);
        checks++; if ({o_lock_lost, o_state} !== {1'b0, 3'd1}) begin errors++;
            $display("FAIL loss_start_clears got=%b want=0001", {o_lock_lost, o_state}); end
    endtask

    task automatic test_bypass_cfg();
        bit ok;
        pulse_start(8'd9, 8'd9, 1'b1, 32'd1000);
        checks++; if ({o_state, pll_bypass, pll_enable, pll_reset, soc_clk_select} !== {3'd5, 4'b1010})
        begin errors++;
            $display("FAIL bypass_outputs got=%b want=1011010",
                     {o_state, pll_bypass, pll_enable, pll_reset, soc_clk_select}); end
        i_cfg_div = 8'd33;
        i_cfg_mul = 8'd44;
        repeat (2) step();
        checks++; if ({pll_div, pll_mul, o_state} !== {8'd9, 8'd9, 3'd5}) begin errors++;
            $display("FAIL cfg_no_start got=%h/%h st=%0d want=09/09 st=5", pll_div, pll_mul, o_state); end
        pll_locked = 1'b0;
        pulse_start(8'd0, 8'd0, 1'b0, 32'd5);
        checks++; if ({pll_div, pll_mul, o_state, pll_bypass} !== {8'd1, 8'd1, 3'd1, 1'b0}) begin
            errors++; $display("FAIL cfg_saturate got=%h/%h st=%0d byp=%0d want=01/01 st=1 byp=0",
                               pll_div, pll_mul, o_state, pll_bypass); end
        wait_state(3'd6, 500, ok);
        checks++; if (!ok || o_timeout_err !== 1'b1) begin errors++;
            $display("FAIL short_timeout_fail got=%0d err=%0d want=6 err=1", o_state, o_timeout_err); end
        i_clear_err = 1'b1;
        pulse_start(8'd5, 8'd6, 1'b0, 32'd5);
        i_clear_err = 1'b0;
        checks++; if ({o_state, pll_div} !== {3'd1, 8'd5}) begin errors++;
            $display("FAIL start_over_clear got=%0d/%h want=1/05", o_state, pll_div); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout();
        test_settle_glitch();
        test_lock_loss();
        test_bypass_cfg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
